// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Flush,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy,
    output logic             Stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  op_r;
    logic        neg_r;
    logic        sign_a_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] opnd_r;
    logic [4:0]  count_r;
    logic [31:0] result_r;
    logic        done_r;
    logic        busy_r;

    logic        sign_a_en_s;
    logic        sign_b_en_s;
    logic        sign_a_s;
    logic        sign_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        is_mul_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic [31:0] special_res_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic        div_ge_s;
    logic [31:0] hi_nx_s;
    logic [31:0] lo_nx_s;
    logic [63:0] prod_s;
    logic [31:0] final_res_s;

    // Operand sign handling and special-case detection at capture time
    always_comb begin
        case (Funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin sign_a_en_s = 1'b1; sign_b_en_s = 1'b1; end
            3'b010:                         begin sign_a_en_s = 1'b1; sign_b_en_s = 1'b0; end
            default:                        begin sign_a_en_s = 1'b0; sign_b_en_s = 1'b0; end
        endcase
        sign_a_s   = sign_a_en_s & SrcA[31];
        sign_b_s   = sign_b_en_s & SrcB[31];
        mag_a_s    = sign_a_s ? (32'd0 - SrcA) : SrcA;
        mag_b_s    = sign_b_s ? (32'd0 - SrcB) : SrcB;
        is_mul_s   = ~Funct3[2];
        div_zero_s = Funct3[2] & (SrcB == 32'd0);
        div_ovf_s  = Funct3[2] & ~Funct3[0] & (SrcA == 32'h8000_0000) & (SrcB == 32'hFFFF_FFFF);
        if (div_zero_s) begin
            special_res_s = Funct3[1] ? SrcA : 32'hFFFF_FFFF;
        end else if (div_ovf_s) begin
            special_res_s = Funct3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_res_s = 32'd0;
        end
    end

    // One multiply or divide step, plus sign fix-up of the finished result
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : 33'd0);
        div_shift_s = {hi_r, lo_r[31]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        if (!op_r[2]) begin
            hi_nx_s = mul_sum_s[32:1];
            lo_nx_s = {mul_sum_s[0], lo_r[31:1]};
        end else if (div_ge_s) begin
            hi_nx_s = div_shift_s[31:0] - opnd_r;
            lo_nx_s = {lo_r[30:0], 1'b1};
        end else begin
            hi_nx_s = div_shift_s[31:0];
            lo_nx_s = {lo_r[30:0], 1'b0};
        end
        prod_s = neg_r ? (64'd0 - {hi_nx_s, lo_nx_s}) : {hi_nx_s, lo_nx_s};
        case (op_r)
            3'b000:                 final_res_s = prod_s[31:0];
            3'b001, 3'b010, 3'b011: final_res_s = prod_s[63:32];
            3'b100, 3'b101:         final_res_s = neg_r ? (32'd0 - lo_nx_s) : lo_nx_s;
            3'b110, 3'b111:         final_res_s = sign_a_r ? (32'd0 - hi_nx_s) : hi_nx_s;
            default:                final_res_s = 32'd0;
        endcase
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            op_r     <= 3'd0;
            neg_r    <= 1'b0;
            sign_a_r <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            opnd_r   <= 32'd0;
            count_r  <= 5'd0;
            result_r <= 32'd0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else if (Flush) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (Start) begin
                        op_r     <= Funct3;
                        neg_r    <= sign_a_s ^ sign_b_s;
                        sign_a_r <= sign_a_s;
                        count_r  <= 5'd0;
                        hi_r     <= 32'd0;
                        lo_r     <= is_mul_s ? mag_b_s : mag_a_s;
                        opnd_r   <= is_mul_s ? mag_a_s : mag_b_s;
                        if (div_zero_s | div_ovf_s) begin
                            result_r <= special_res_s;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    hi_r    <= hi_nx_s;
                    lo_r    <= lo_nx_s;
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        result_r <= final_res_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Result = result_r;
    assign Done   = done_r;
    assign Busy   = busy_r;
    // Stall must rise in the Start cycle itself, so it cannot be registered
    assign Stall  = ((state_r == ST_IDLE) & Start & ~Flush) | (state_r == ST_CALC);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the Execute stage, alongside the ALU. Operands come from the forwarding mux outputs (SrcA/SrcB). The unit stalls the pipeline through a Stall output while it computes. Its result is selected into the Alu_Result_M path when Done is high.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.

Ports:
Clk  input  1  clock; all state changes on posedge.
Reset  input  1  asynchronous, active-high; clock Clk.
Start  input  1  Execute-stage instruction is an M-extension op (opcode 0110011, funct7 0000001).
Flush  input  1  Execute-stage flush from the hazard unit; aborts any operation.
Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
SrcA  input  32  rs1 operand, after forwarding.
SrcB  input  32  rs2 operand, after forwarding.
Result  output  32  registered result; valid while Done=1, held until the next capture.
Done  output  1  high for exactly one cycle when Result is valid.
Busy  output  1  registered; high while in CALC.
Stall  output  1  combinational; (IDLE & Start & ~Flush) | CALC; drives stall of F/D/E and flush of M.

Behaviour:
- Reset: state IDLE, Result=0, Done=0, Busy=0, counter=0, internal accumulators=0. Reset mid-operation aborts immediately; no Done is produced.
- States: IDLE, CALC, DONE.
- IDLE: on an edge with Start=1 and Flush=0, capture Funct3, operand signs, magnitudes and raw operands.
  - If the op is a special case, go to DONE with the result preloaded.
  - Otherwise go to CALC with counter=0.
- CALC: one iteration per edge, counter increments each edge. The edge that performs iteration 31 (counter==31) moves to DONE and writes Result.
- Normal latency: Start sampled at edge N, Done high in the cycle after edge N+32. Stall is high from the Start cycle through the last CALC cycle (33 cycles).
- DONE: Done=1, Stall=0, so the pipeline advances at the end of this cycle. Start is ignored in DONE (it is still the same instruction). The next edge always returns to IDLE.
- Flush: in any state, the next edge returns to IDLE with Done=0. Result is not updated. Flush overrides Start.
- Multiply (radix-2 shift-add, unsigned 32x32 to 64 bits on magnitudes):
  - Signed operands: MUL/MULH treat both as signed; MULHSU treats only SrcA as signed; MULHU treats both as unsigned.
  - Negate the 64-bit product if the operand signs differ.
  - MUL returns product[31:0]; the others return product[63:32].
- Divide (restoring, on magnitudes; DIV/REM are signed, DIVU/REMU unsigned):
  - Quotient sign = signA ^ signB.
  - Remainder sign = signA.
- Special cases (1-cycle path; Done in the cycle after the Start edge):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcA.
  - Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Operands are latched at capture; changes on SrcA/SrcB during CALC have no effect.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> Done 33 cycles after Start, Result 0xFFFFFFEB. Stall high for 33 cycles, low during Done.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each with Done one cycle after Start. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush at CALC cycle 10 -> IDLE next edge, no Done, Result unchanged. A back-to-back Start afterwards completes normally.
- Reset asserted mid-CALC (asynchronously, between edges) -> Busy/Done/Result go to 0 immediately. Start after Reset is released yields a correct result.
